// File: rtl/wb_bridge_pkg.sv
// Shared encodings and helpers for the Wishbone single-transfer initiator.
package wb_bridge_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Size 3 is reserved and is always rejected as misaligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = |addr_lo;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/wb_lane_steer.sv
// Little-endian byte-lane steering: byte selects, write replication, read extraction.
module wb_lane_steer
    import wb_bridge_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_raw_i,
    input  logic        signed_i,
    output logic [3:0]  sel_c,
    output logic [31:0] wdat_c,
    output logic [31:0] rdata_c
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_raw_i >> {addr_lo_i, 3'b000};
        sel_c   = 4'b0000;
        wdat_c  = wdata_i;
        rdata_c = rdata_raw_i;
        case (size_i)
            SIZE_BYTE: begin
                sel_c   = 4'b0001 << addr_lo_i;
                wdat_c  = {4{wdata_i[7:0]}};
                rdata_c = {{24{signed_i & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                sel_c   = 4'b0011 << addr_lo_i;
                wdat_c  = {2{wdata_i[15:0]}};
                rdata_c = {{16{signed_i & shifted[15]}}, shifted[15:0]};
            end
            SIZE_WORD: begin
                sel_c = 4'b1111;
            end
            default: begin
                sel_c = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer initiator bridging CPU load/store requests.
module wb_master_bridge
    import wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic [1:0]         size_q, size_d;
    logic               signed_q, signed_d;
    logic [1:0]         alo_q, alo_d;

    logic [1:0]         steer_size;
    logic [1:0]         steer_alo;
    logic               steer_signed;
    logic [3:0]         steer_sel;
    logic [31:0]        steer_wdat;
    logic [31:0]        steer_rdata;

    // One steering instance: request fields while idle, latched fields during the cycle.
    assign steer_size   = (state_q == IDLE) ? size_i        : size_q;
    assign steer_alo    = (state_q == IDLE) ? addr_i[1:0]   : alo_q;
    assign steer_signed = (state_q == IDLE) ? signed_i      : signed_q;

    wb_lane_steer u_steer (
        .size_i      (steer_size),
        .addr_lo_i   (steer_alo),
        .wdata_i     (wdata_i),
        .rdata_raw_i (dat_i),
        .signed_i    (steer_signed),
        .sel_c       (steer_sel),
        .wdat_c      (steer_wdat),
        .rdata_c     (steer_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        we_d     = we_q;
        sel_d    = sel_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        size_d   = size_q;
        signed_d = signed_q;
        alo_d    = alo_q;

        case (state_q)
            IDLE: begin
                if (req_i && ready_q) begin
                    if (misaligned(size_i, addr_i[1:0])) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = BUS;
                        cyc_d    = 1'b1;
                        stb_d    = 1'b1;
                        we_d     = we_i;
                        sel_d    = steer_sel;
                        adr_d    = {addr_i[31:2], 2'b00};
                        dat_d    = steer_wdat;
                        size_d   = size_i;
                        signed_d = signed_i;
                        alo_d    = addr_i[1:0];
                        cnt_d    = '0;
                    end
                end
            end
            BUS: begin
                if (err_i) begin
                    state_d = RESP;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (ack_i) begin
                    state_d = RESP;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = steer_rdata;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d = RESP;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            size_q   <= SIZE_BYTE;
            signed_q <= 1'b0;
            alo_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            alo_q    <= alo_d;
        end
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;
    assign cyc_o   = cyc_q;
    assign stb_o   = stb_q;
    assign we_o    = we_q;
    assign sel_o   = sel_q;
    assign adr_o   = adr_q;
    assign dat_o   = dat_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Scoreboard bench: issued requests queue expected bus and response records; monitors compare.
module tb_wb_master_bridge;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        signed_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;

    always #5 clk = ~clk;

    wb_master_bridge #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .size_i   (size_i),
        .signed_i (signed_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .ready_o  (ready_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .rdata_o  (rdata_o),
        .cyc_o    (cyc_o),
        .stb_o    (stb_o),
        .we_o     (we_o),
        .sel_o    (sel_o),
        .adr_o    (adr_o),
        .dat_o    (dat_o),
        .dat_i    (dat_i),
        .ack_i    (ack_i),
        .err_i    (err_i)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        string       name;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        int          len;
        string       name;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: every done_o pulse must match the oldest queued expectation.
    always @(negedge clk) begin : rsp_mon
        rsp_t r;
        if (done_o) begin
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 expected no response pending");
            end else begin
                r = rsp_q.pop_front();
                check32({r.name, "_err"}, 32'(err_o), 32'(r.err));
                check32({r.name, "_rdata"}, rdata_o, r.rdata);
            end
        end
    end

    // Bus monitor: checks the payload of each Wishbone cycle, its stability and its length.
    logic in_cyc = 1'b0;
    int   cyc_len = 0;
    bus_t cur_bus;
    always @(negedge clk) begin : bus_mon
        if (cyc_o) begin
            if (!in_cyc) begin
                in_cyc  = 1'b1;
                cyc_len = 0;
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cyc: got cyc_o=1 adr=0x%08h expected no cycle", adr_o);
                    cur_bus.len  = 0;
                    cur_bus.name = "unexpected";
                    cur_bus.we   = we_o;
                    cur_bus.sel  = sel_o;
                    cur_bus.adr  = adr_o;
                    cur_bus.dat  = dat_o;
                end else begin
                    cur_bus = bus_q.pop_front();
                end
            end
            cyc_len++;
            check32({cur_bus.name, "_adr"}, adr_o, cur_bus.adr);
            check32({cur_bus.name, "_sel"}, 32'(sel_o), 32'(cur_bus.sel));
            check32({cur_bus.name, "_dat"}, dat_o, cur_bus.dat);
            check32({cur_bus.name, "_we"}, 32'(we_o), 32'(cur_bus.we));
            check32({cur_bus.name, "_stb"}, 32'(stb_o), 32'd1);
        end else if (in_cyc) begin
            in_cyc = 1'b0;
            if (cur_bus.len != 0) begin
                check32({cur_bus.name, "_cyclen"}, 32'(cyc_len), 32'(cur_bus.len));
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_wait: got ready_o=0 expected 1 within 100 cycles", name);
        end
    endtask

    // mode: 0 no response, 1 ack, 2 err, 3 ack+err; delay = BUS cycles before the response.
    task automatic issue(input string name, input logic we, input logic [1:0] size,
                         input logic sg, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdat, input int mode, input int delay,
                         input logic bus, input logic [3:0] esel, input logic [31:0] edat,
                         input int elen, input logic eerr, input logic [31:0] erdata,
                         input logic hold);
        rsp_t r;
        bus_t b;
        wait_ready(name);
        req_i    = 1'b1;
        we_i     = we;
        size_i   = size;
        signed_i = sg;
        addr_i   = addr;
        wdata_i  = wdata;
        r.err    = eerr;
        r.rdata  = erdata;
        r.name   = name;
        rsp_q.push_back(r);
        if (bus) begin
            b.we   = we;
            b.sel  = esel;
            b.adr  = {addr[31:2], 2'b00};
            b.dat  = edat;
            b.len  = elen;
            b.name = name;
            bus_q.push_back(b);
        end
        @(posedge clk);
        #1;
        if (!hold) req_i = 1'b0;
        if (!bus) begin
            @(negedge clk);
            check32({name, "_lat_done"}, 32'(done_o), 32'd1);
            check32({name, "_no_cyc"}, 32'(cyc_o), 32'd0);
        end else if (mode == 0) begin
            @(negedge clk);
            req_i = 1'b0;
            wait_ready(name);
        end else begin
            @(negedge clk);
            repeat (delay) @(negedge clk);
            req_i = 1'b0;
            dat_i = rdat;
            ack_i = (mode != 2);
            err_i = (mode >= 2);
            @(posedge clk);
            #1;
            ack_i = 1'b0;
            err_i = 1'b0;
            dat_i = 32'h0;
            @(negedge clk);
            check32({name, "_lat_done"}, 32'(done_o), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus_t b;
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0; signed_i = 1'b0;
        addr_i = 32'h0; wdata_i = 32'h0; dat_i = 32'h0; ack_i = 1'b0; err_i = 1'b0;
        repeat (3) @(negedge clk);
        check32("rst_ready", 32'(ready_o), 32'd1);
        check32("rst_cyc",   32'(cyc_o),   32'd0);
        check32("rst_stb",   32'(stb_o),   32'd0);
        check32("rst_we",    32'(we_o),    32'd0);
        check32("rst_sel",   32'(sel_o),   32'd0);
        check32("rst_adr",   adr_o,        32'd0);
        check32("rst_dat",   dat_o,        32'd0);
        check32("rst_done",  32'(done_o),  32'd0);
        check32("rst_err",   32'(err_o),   32'd0);
        check32("rst_rdata", rdata_o,      32'd0);
        rst_i = 1'b0;
        @(negedge clk);

        //     name        we    sz    sg    addr          wdata         rdat          md dly bus  sel      edat          len eerr  erdata        hold
        issue("word_st",  1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1, 3, 1'b1, 4'b1111, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0000, 1'b1);
        issue("ld_b_s",   1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'h0,        32'h8011_2233, 1, 0, 1'b1, 4'b1000, 32'h0,         0, 1'b0, 32'hFFFF_FF80, 1'b0);
        issue("ld_b_u",   1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'h0,        32'h8011_2233, 1, 0, 1'b1, 4'b1000, 32'h0,         0, 1'b0, 32'h0000_0080, 1'b0);
        issue("st_h",     1'b1, 2'd1, 1'b0, 32'h0000_0302, 32'h0000_A55A, 32'h0,        1, 1, 1'b1, 4'b1100, 32'hA55A_A55A, 0, 1'b0, 32'h0000_0080, 1'b0);
        issue("ld_h_mis", 1'b0, 2'd1, 1'b0, 32'h0000_0301, 32'h0,        32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,         0, 1'b1, 32'h0000_0080, 1'b0);
        issue("timeout",  1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0,        32'h0,        0, 0, 1'b1, 4'b1111, 32'h0,         8, 1'b1, 32'h0000_0080, 1'b0);
        issue("ack_last", 1'b0, 2'd2, 1'b0, 32'h0000_0404, 32'h0,        32'h1234_5678, 1, 7, 1'b1, 4'b1111, 32'h0,         8, 1'b0, 32'h1234_5678, 1'b0);
        issue("ack_err",  1'b0, 2'd0, 1'b0, 32'h0000_0000, 32'h0,        32'h0000_00FF, 3, 0, 1'b1, 4'b0001, 32'h0,         0, 1'b1, 32'h1234_5678, 1'b0);
        issue("ld_h_s",   1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0,        32'h8001_0000, 1, 2, 1'b1, 4'b1100, 32'h0,         0, 1'b0, 32'hFFFF_8001, 1'b0);
        issue("st_b",     1'b1, 2'd0, 1'b0, 32'h0000_0501, 32'h0000_00AB, 32'h0,        1, 0, 1'b1, 4'b0010, 32'hABAB_ABAB, 0, 1'b0, 32'hFFFF_8001, 1'b0);
        issue("size3",    1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,         0, 1'b1, 32'hFFFF_8001, 1'b0);
        issue("ld_w_mis", 1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0,        32'h0,        0, 0, 1'b0, 4'b0000, 32'h0,         0, 1'b1, 32'hFFFF_8001, 1'b0);
        issue("st_err",   1'b1, 2'd2, 1'b0, 32'h0000_0700, 32'h1122_3344, 32'h0,        2, 1, 1'b1, 4'b1111, 32'h1122_3344, 0, 1'b1, 32'hFFFF_8001, 1'b0);

        // Reset during the second BUS cycle: cycle drops, no completion.
        wait_ready("mid_rst");
        req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; signed_i = 1'b0;
        addr_i = 32'h0000_0600; wdata_i = 32'h0;
        b.we = 1'b0; b.sel = 4'b1111; b.adr = 32'h0000_0600; b.dat = 32'h0; b.len = 0; b.name = "mid_rst";
        bus_q.push_back(b);
        @(posedge clk);
        #1;
        req_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check32("mid_rst_cyc",   32'(cyc_o),   32'd0);
        check32("mid_rst_stb",   32'(stb_o),   32'd0);
        check32("mid_rst_ready", 32'(ready_o), 32'd1);
        check32("mid_rst_done",  32'(done_o),  32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        check32("mid_rst_rdata", rdata_o, 32'd0);

        issue("after_rst", 1'b0, 2'd1, 1'b0, 32'h0000_0606, 32'h0, 32'hBEEF_0000, 1, 0, 1'b1, 4'b1100, 32'h0, 0, 1'b0, 32'h0000_BEEF, 1'b0);

        repeat (5) @(negedge clk);
        check32("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        check32("bus_q_empty", 32'(bus_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
Wishbone classic single-transfer initiator. It converts the CPU core's simple load/store request into Wishbone cycles aimed at slaves such as the PSRAM controller wrapper. It generates byte selects, steers write data onto byte lanes, and extracts and extends read data. It also detects misaligned accesses, propagates slave errors, and aborts hung cycles with a timeout.

Parameters:
TIMEOUT, 256, bus cycles allowed in BUS before abort with error; 0 disables the timeout.
CNT_W, 16, timeout counter width; must satisfy TIMEOUT < 2**CNT_W.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
req_i  in  1  CPU request valid
we_i  in  1  1 = store, 0 = load
size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as misaligned)
signed_i  in  1  sign-extend load result
addr_i  in  32  byte address
wdata_i  in  32  store data, right-justified
ready_o  out  1  bridge idle; request accepted when req_i & ready_o
done_o  out  1  one-cycle completion pulse
err_o  out  1  valid with done_o: misaligned, slave error or timeout
rdata_o  out  32  load result, valid with done_o, held until next done_o
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
we_o  out  1  Wishbone write enable
sel_o  out  4  Wishbone byte selects
adr_o  out  32  Wishbone address, word aligned ({addr[31:2],2'b00})
dat_o  out  32  Wishbone write data
dat_i  in  32  Wishbone read data
ack_i  in  1  Wishbone acknowledge
err_i  in  1  Wishbone error

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous and active-high. On reset the state is IDLE and outputs are: cyc_o=stb_o=we_o=0, sel_o=0, adr_o=0, dat_o=0, done_o=err_o=0, rdata_o=0, ready_o=1. The timeout counter clears.
- Byte lane convention: little-endian.
  - Byte access: sel = 1<<addr[1:0].
  - Half access: sel = 4'b0011 << addr[1:0]; addr[0] must be 0.
  - Word access: sel = 4'b1111; addr[1:0] must be 00.
- Write data replication: byte writes drive {4{wdata[7:0]}}; half writes drive {2{wdata[15:0]}}; word writes drive wdata.
- Read extraction: the lane selected by addr[1:0] is shifted down, then zero-extended or sign-extended per signed_i. Word reads ignore signed_i.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - ready_o=1.
  - Aligned request: latch we, size, signed, addr[1:0], computed sel, adr and dat into output registers, set cyc_o=stb_o=1 and go to BUS. Cycle-1 bus assertion: the Wishbone outputs are registered and appear on the edge after acceptance.
  - Misaligned request (or size 3): no bus cycle is issued. Go to RESP with err flag set.
- BUS:
  - ready_o=0; cyc_o and stb_o are held high and all Wishbone outputs are stable.
  - ack_i: capture the extracted read data into rdata_o (loads only; stores leave rdata_o unchanged), drop cyc_o and stb_o, go to RESP with err=0.
  - err_i: drop cyc_o and stb_o, go to RESP with err=1. If ack_i and err_i are high together, err_i wins.
  - Timeout: the counter increments each BUS cycle without a response. When the count equals TIMEOUT-1 and there is no ack_i or err_i in that cycle, abort: drop cyc_o and stb_o and go to RESP with err=1. A response in the same cycle as expiry is honoured.
- RESP:
  - done_o=1 and err_o=err for exactly one cycle, then go to IDLE. ready_o=0 in RESP.
  - Back-to-back requests: minimum spacing is one IDLE cycle between accepted requests.
- Latency: with an ack in the first BUS cycle, acceptance occurs at cycle 0, stb at cycle 1, ack at cycle 1, done at cycle 2.
- Mid-cycle reset: reset asserted during BUS drops cyc_o and stb_o at the next edge. No done_o is produced.
- req_i while not ready: ignored, not queued.

Decomposition:
- Shared package wb_bridge_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings;
  - state encoding IDLE/BUS/RESP;
  - function misaligned(size, addr[1:0]).
- One natural sub-module: wb_lane_steer, a purely combinational block.
  - Inputs: size, addr[1:0], wdata, rdata_raw, signed.
  - Outputs: sel, dat_o value, extracted rdata.
- The top level holds the FSM, the output registers and the timeout counter.

Test Plan:
1. Word store: addr=0x100, wdata=0xDEADBEEF, ack after 3 cycles -> adr_o=0x100, sel_o=1111, dat_o=0xDEADBEEF, we_o=1; done_o pulses one cycle after ack with err_o=0.
2. Signed byte load: addr=0x203, dat_i=0x80112233 -> sel_o=1000, adr_o=0x200, rdata_o=0xFFFFFF80. Repeat unsigned -> 0x00000080.
3. Half store: addr=0x302, wdata=0x0000A55A -> sel_o=1100, dat_o=0xA55AA55A. Half load from addr=0x301 -> no cyc_o, done_o with err_o=1 one cycle after acceptance.
4. Timeout with TIMEOUT=8: never ack -> cyc_o high for exactly 8 cycles, then low; done_o=1, err_o=1. Also ack in the 8th cycle -> err_o=0.
5. Slave error: err_i and ack_i together in the first BUS cycle -> err_o=1, rdata_o unchanged from its previous value.
6. Reset in the 2nd BUS cycle -> cyc_o=stb_o=0 and ready_o=1 at the next edge; no done_o; the next request completes normally.
